muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer that owns the HI/LO register pair of the CPU. It executes MIPS `mult`, `multu`, `div` and `divu` over 34 cycles with a radix-2 shift/add–subtract engine. It also services `mthi`/`mtlo` writes. It sits beside the single-cycle ALU in the EX stage, and the pipeline stalls on `busy`.

---
 rtl/muldiv_ctrl.sv | 161 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide, 34 cycles start to done.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   abs_a_reg, abs_b_reg, raw_a_reg;
  logic               sign_a_reg, sign_b_reg, bzero_reg;
  logic [5:0]         cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic               busy_reg, done_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  // Operand conditioning for the start edge; op[0]=1 means unsigned.
  logic             in_sign_a, in_sign_b;
  logic [WIDTH-1:0] in_abs_a, in_abs_b;

  always_comb begin
    in_sign_a = a[WIDTH-1] & ~op[0];
    in_sign_b = b[WIDTH-1] & ~op[0];
    in_abs_a  = in_sign_a ? (~a + 1'b1) : a;
    in_abs_b  = in_sign_b ? (~b + 1'b1) : b;
  end

  // One multiply step: conditional add into P_hi with carry, then shift right.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    add_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
               (acc_reg[0] ? {1'b0, abs_a_reg} : {(WIDTH+1){1'b0}});
    mul_next = {add_sum, acc_reg[WIDTH-1:1]};
  end

  // One restoring divide step on {R, Q}; the extra diff bit acts as borrow.
  logic [WIDTH:0]     r_shift;
  logic [WIDTH+1:0]   diff;
  logic               diff_neg;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    r_shift  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    diff     = {1'b0, r_shift} - {2'b00, abs_b_reg};
    diff_neg = diff[WIDTH+1];
    div_next = {(diff_neg ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0]),
                acc_reg[WIDTH-2:0], ~diff_neg};
  end

  // Sign correction and result selection used on the FIX -> DONE edge.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_hi, fix_lo;

  always_comb begin
    prod_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
    quot_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg[WIDTH-1:0] + 1'b1)
                                         : acc_reg[WIDTH-1:0];
    rem_fix  = sign_a_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                          : acc_reg[2*WIDTH-1:WIDTH];
    if (!op_reg[1]) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (bzero_reg) begin
      fix_hi = raw_a_reg;
      fix_lo = {WIDTH{1'b1}};
    end else begin
      fix_hi = rem_fix;
      fix_lo = quot_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= 2'b00;
      abs_a_reg  <= '0;
      abs_b_reg  <= '0;
      raw_a_reg  <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      bzero_reg  <= 1'b0;
      cnt_reg    <= 6'd0;
      acc_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hi_we) hi_reg <= wdata;
          if (lo_we) lo_reg <= wdata;
          if (start && !flush) begin
            state_reg  <= RUN;
            busy_reg   <= 1'b1;
            op_reg     <= op;
            abs_a_reg  <= in_abs_a;
            abs_b_reg  <= in_abs_b;
            raw_a_reg  <= a;
            sign_a_reg <= in_sign_a;
            sign_b_reg <= in_sign_b;
            bzero_reg  <= (b == '0);
            cnt_reg    <= 6'd0;
            // Multiply starts with the multiplier in P_lo, divide with the dividend in Q.
            acc_reg    <= {{WIDTH{1'b0}}, (op[1] ? in_abs_a : in_abs_b)};
          end
        end
        RUN: begin
          if (flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            acc_reg <= op_reg[1] ? div_next : mul_next;
            cnt_reg <= cnt_reg + 6'd1;
            if (cnt_reg == 6'(WIDTH - 1)) state_reg <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            hi_reg    <= fix_hi;
            lo_reg    <= fix_lo;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic model of
// MIPS mult/multu/div/divu and the mthi/mtlo/flush/reset behaviour.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      p;
    int          q, r;
    logic [63:0] pu;
    case (o)
      OP_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
      end
      OP_MULTU: begin
        pu = {32'b0, x} * {32'b0, y};
        return pu;
      end
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // mode: 0 plain, 1 flush at cycle at_k, 2 reset at cycle at_k,
  //       3 lo_we on start edge with lo hold check at at_k, 4 start/hi_we disturbance at at_k.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int mode, input int at_k);
    int          k, busy_cnt;
    bit          seen_done;
    logic [63:0] res;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (mode == 3) begin
      lo_we = 1'b1; wdata = 32'h12345678; exp_lo = 32'h12345678;
    end
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    k = 0; busy_cnt = 0; seen_done = 1'b0;
    while (!done && k < 100) begin
      start = 1'b0; hi_we = 1'b0;
      if (busy) busy_cnt++;
      if (mode == 3 && k == at_k) check("lo_hold", lo, exp_lo);
      if (mode == 4 && k == at_k) begin
        start = 1'b1; op = ~o; a = 32'h11; b = 32'h3;
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
      end
      if (mode == 1 && k == at_k) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        repeat (40) begin
          @(negedge clk);
          if (done) seen_done = 1'b1;
        end
        check("flush_no_done", seen_done, 0);
        check("flush_hi", hi, exp_hi);
        check("flush_lo", lo, exp_lo);
        return;
      end
      if (mode == 2 && k == at_k) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
          @(negedge clk);
          if (done || busy) seen_done = 1'b1;
        end
        check("rst_quiet", seen_done, 0);
        check("rst_hi_after", hi, 0);
        check("rst_lo_after", lo, 0);
        return;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; hi_we = 1'b0;
    if (busy) busy_cnt++;
    check("latency", k, 33);
    check("busy_cycles", busy_cnt, 34);
    res = model(o, x, y);
    exp_hi = res[63:32];
    exp_lo = res[31:0];
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h)", o, x, y, hi, lo, exp_hi, exp_lo);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    rst_n = 1'b1;

    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    do_op(OP_MULT,  32'hFFFFFFFD, 32'd7, 0, 0);
    do_op(OP_DIV,   32'hFFFFFFF9, 32'd2, 0, 0);
    do_op(OP_DIVU,  32'd100, 32'd0, 0, 0);
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0);
    do_op(OP_DIV,   32'hFFFFFF9C, 32'd0, 0, 0);
    do_op(OP_MULTU, 32'd5, 32'd6, 1, 10);
    do_op(OP_DIVU,  32'd17, 32'd5, 0, 0);
    do_op(OP_MULT,  32'h12345678, 32'h9ABCDEF0, 4, 5);
    do_op(OP_MULTU, 32'd2, 32'd3, 3, 20);

    // Idle mthi/mtlo with flush asserted: writes land, start is dropped.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hCAFEF00D; start = 1'b1; flush = 1'b1; op = OP_MULTU;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b0; flush = 1'b0;
    exp_hi = 32'hCAFEF00D;
    check("idle_flush_busy", busy, 0);
    check("mthi", hi, exp_hi);
    check("mthi_lo", lo, exp_lo);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: ra = 32'h80000000;
        default: ;
      endcase
      do_op(ro, ra, rb, 0, 0);
    end

    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 2, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
